// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo_thr FIFO.
//   fifo_mode_e : read-side behaviour, registered (FIFO_STD) or first-word fall-through
//   ptr_width() : pointer width for a given depth (address bits plus one wrap bit)
package sync_fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_thr: WIDTH x DEPTH registers, no reset.
// Ports:
//   clk   in  clock, rising edge
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out read data (asynchronous)
module sync_fifo_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and a
// selectable read stage (registered or first-word fall-through).
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN enables the sticky overflow/underflow flags;
// without it both outputs are tied low and refused accesses are dropped silently.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   wr_en, wr_data    write request and data; accepted when wr_ready is high
//   wr_ready          space available (not full)
//   rd_en             read request / pop
//   rd_data, rd_valid read data and its qualifier (timing depends on MODE)
//   count             stored words, 0..DEPTH
//   almost_full       count >= AFULL_THR
//   almost_empty      count <= AEMPTY_THR
//   overflow          sticky: write attempted while full
//   underflow         sticky: read attempted while empty
module sync_fifo_thr
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AFULL_THR  = DEPTH - 2,
    parameter int unsigned AEMPTY_THR = 2,
    parameter fifo_mode_e  MODE       = FIFO_STD
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_ready,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned AW = PW - 1;

    localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_THR);
    localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_THR);

    // Elaboration-time parameter checks.
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_thr: WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_thr: DEPTH must be a power of two >= 2");
    end
    if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull
        $error("sync_fifo_thr: AFULL_THR must be in 1..DEPTH");
    end
    if (AEMPTY_THR > DEPTH - 1) begin : g_bad_aempty
        $error("sync_fifo_thr: AEMPTY_THR must be in 0..DEPTH-1");
    end

    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic             full;
    logic             empty;
    logic             wr_fire;
    logic             rd_fire;
    logic [WIDTH-1:0] mem_rdata;

    // The extra pointer MSB makes the modulo difference distinguish full from empty.
    assign count        = wptr_q - rptr_q;
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign wr_ready     = ~full;
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_fire) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_fire) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wptr_q[AW-1:0]),
        .wdata (wr_data),
        .raddr (rptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    if (MODE == FIFO_STD) begin : g_std
        logic [WIDTH-1:0] rd_data_q;
        logic             rd_valid_q;

        // rd_data holds its last value between reads; rd_valid pulses once per pop.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_fire;
                if (rd_fire) begin
                    rd_data_q <= mem_rdata;
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft
        // Head of queue is always presented; a word written this cycle appears next cycle.
        assign rd_data  = mem_rdata;
        assign rd_valid = ~empty;
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_thr.sv
module tb_sync_fifo_thr;
    import sync_fifo_pkg::*;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Registered-read instance
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_ready;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [3:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       overflow;
    logic       underflow;

    // FWFT instance
    logic       f_wr_en = 1'b0;
    logic [7:0] f_wr_data = '0;
    logic       f_wr_ready;
    logic       f_rd_en = 1'b0;
    logic [7:0] f_rd_data;
    logic       f_rd_valid;
    logic [3:0] f_count;
    logic       f_almost_full;
    logic       f_almost_empty;
    logic       f_overflow;
    logic       f_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_q[$];  // words held by the FIFO
    logic [7:0] exp_q[$];    // words popped, awaiting appearance on rd_data
    bit         exp_rv;      // a read was accepted on the last drive

    always #5 clk = ~clk;

    sync_fifo_thr #(
        .WIDTH      (8),
        .DEPTH      (8),
        .AFULL_THR  (6),
        .AEMPTY_THR (2),
        .MODE       (FIFO_STD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    sync_fifo_thr #(
        .WIDTH      (8),
        .DEPTH      (8),
        .AFULL_THR  (6),
        .AEMPTY_THR (2),
        .MODE       (FIFO_FWFT)
    ) dut_fwft (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (f_wr_en),
        .wr_data      (f_wr_data),
        .wr_ready     (f_wr_ready),
        .rd_en        (f_rd_en),
        .rd_data      (f_rd_data),
        .rd_valid     (f_rd_valid),
        .count        (f_count),
        .almost_full  (f_almost_full),
        .almost_empty (f_almost_empty),
        .overflow     (f_overflow),
        .underflow    (f_underflow)
    );

    task automatic do_reset();
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        f_wr_en = 1'b0;
        f_rd_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_q.delete();
        exp_q.delete();
        exp_rv = 1'b0;
    endtask

    // One clock of stimulus on the registered instance; updates the model only.
    task automatic drive(input bit we, input logic [7:0] wd, input bit re);
        bit wr_acc;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        wr_acc  = we && (model_q.size() < 8);
        exp_rv  = re && (model_q.size() > 0);
        if (exp_rv) exp_q.push_back(model_q.pop_front());
        if (wr_acc) model_q.push_back(wd);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (count !== 4'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d want 0", count);
        end
        n_checks++;
        if ({rd_valid, wr_ready, almost_empty, almost_full} !== 4'b0110) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0110",
                               {rd_valid, wr_ready, almost_empty, almost_full});
        end
        n_checks++;
        if ({overflow, underflow} !== 2'b00 || rd_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_err_data: got ovf/unf %b data %h want 00 data 00",
                               {overflow, underflow}, rd_data);
        end
        n_checks++;
        if (f_rd_valid !== 1'b0 || f_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_fwft: got valid %b count %0d want 0 0",
                               f_rd_valid, f_count);
        end
    endtask

    task automatic test_std_read();
        logic [7:0] wvals [3];
        logic [7:0] e;
        wvals[0] = 8'h11; wvals[1] = 8'h22; wvals[2] = 8'h33;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, wvals[i], 1'b0);
            n_checks++;
            if (count !== 4'(model_q.size()) || almost_empty !== (model_q.size() <= 2)) begin
                n_fail++; $display("FAIL std_write_count: got %0d ae %b want %0d ae %b", count,
                                   almost_empty, model_q.size(), model_q.size() <= 2);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== e) begin
                n_fail++; $display("FAIL std_read_data: got valid %b data %h want 1 %h",
                                   rd_valid, rd_data, e);
            end
            n_checks++;
            if (count !== 4'(model_q.size()) || almost_empty !== 1'b1) begin
                n_fail++; $display("FAIL std_read_count: got %0d ae %b want %0d ae 1",
                                   count, almost_empty, model_q.size());
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h33) begin
            n_fail++; $display("FAIL std_hold: got valid %b data %h want 0 33", rd_valid, rd_data);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hC0 + 8'(i), 1'b0);
            n_checks++;
            if (count !== 4'(model_q.size()) || almost_full !== (model_q.size() >= 6)) begin
                n_fail++; $display("FAIL fill_count: got %0d af %b want %0d af %b", count,
                                   almost_full, model_q.size(), model_q.size() >= 6);
            end
        end
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++; $display("FAIL full_ready: got %b want 0", wr_ready);
        end
        drive(1'b1, 8'hFF, 1'b0);
        n_checks++;
        if (count !== 4'd8 || overflow !== ERR_EN || underflow !== 1'b0) begin
            n_fail++; $display("FAIL overflow: got count %0d ovf %b unf %b want 8 %b 0",
                               count, overflow, underflow, ERR_EN);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== e || count !== 4'(model_q.size())) begin
                n_fail++; $display("FAIL drain: got valid %b data %h count %0d want 1 %h %0d",
                                   rd_valid, rd_data, count, e, model_q.size());
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'h50 + 8'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'h80 + 8'(i), 1'b1);
            e = exp_q.pop_front();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== e || count !== 4'd3) begin
                n_fail++; $display("FAIL wrap: got valid %b data %h count %0d want 1 %h 3",
                                   rd_valid, rd_data, count, e);
            end
        end
        n_checks++;
        if ({overflow, underflow} !== 2'b00) begin
            n_fail++; $display("FAIL wrap_flags: got %b want 00", {overflow, underflow});
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] e;
        bit         bad;
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 8'h20 + 8'(i), 1'b0);
        drive(1'b1, 8'hEE, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== e || count !== 4'd7) begin
            n_fail++; $display("FAIL full_rw: got valid %b data %h count %0d want 1 %h 7",
                               rd_valid, rd_data, count, e);
        end
        bad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            e = exp_q.pop_front();
            if (rd_data !== e) bad = 1'b1;
        end
        n_checks++;
        if (bad || count !== 4'd0) begin
            n_fail++; $display("FAIL full_rw_drain: got mismatch %b count %0d want 0 0", bad, count);
        end
    endtask

    task automatic test_fwft();
        logic [7:0] fq[$];
        logic [7:0] e;
        do_reset();
        f_wr_en = 1'b1; f_wr_data = 8'hA5;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        n_checks++;
        if (f_rd_valid !== 1'b1 || f_rd_data !== 8'hA5) begin
            n_fail++; $display("FAIL fwft_show: got valid %b data %h want 1 a5", f_rd_valid, f_rd_data);
        end
        @(posedge clk); #1;
        n_checks++;
        if (f_rd_valid !== 1'b1 || f_rd_data !== 8'hA5 || f_count !== 4'd1) begin
            n_fail++; $display("FAIL fwft_hold: got valid %b data %h count %0d want 1 a5 1",
                               f_rd_valid, f_rd_data, f_count);
        end
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (f_rd_valid !== 1'b0 || f_count !== 4'd0) begin
            n_fail++; $display("FAIL fwft_pop: got valid %b count %0d want 0 0", f_rd_valid, f_count);
        end
        @(posedge clk); #1;  // rd_en still high on an empty FIFO
        f_rd_en = 1'b0;
        n_checks++;
        if (f_count !== 4'd0 || f_underflow !== ERR_EN || f_overflow !== 1'b0) begin
            n_fail++; $display("FAIL fwft_underflow: got count %0d unf %b ovf %b want 0 %b 0",
                               f_count, f_underflow, f_overflow, ERR_EN);
        end
        for (int i = 0; i < 3; i++) begin
            f_wr_en = 1'b1; f_wr_data = 8'hB1 + 8'(i);
            fq.push_back(f_wr_data);
            @(posedge clk); #1;
        end
        f_wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e = fq.pop_front();
            n_checks++;
            if (f_rd_valid !== 1'b1 || f_rd_data !== e) begin
                n_fail++; $display("FAIL fwft_stream: got valid %b data %h want 1 %h",
                                   f_rd_valid, f_rd_data, e);
            end
            f_rd_en = 1'b1;
            @(posedge clk); #1;
            f_rd_en = 1'b0;
        end
        n_checks++;
        if (f_rd_valid !== 1'b0 || f_count !== 4'd0) begin
            n_fail++; $display("FAIL fwft_empty: got valid %b count %0d want 0 0", f_rd_valid, f_count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) drive(1'b1, 8'h60 + 8'(i), 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (count !== 4'd5 || rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset: got count %0d valid %b want 5 1", count, rd_valid);
        end
        #2;
        rst = 1'b1;
        #1;  // no clock edge between assertion and check
        n_checks++;
        if (count !== 4'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset: got count %0d valid %b ready %b want 0 0 1",
                               count, rd_valid, wr_ready);
        end
        n_checks++;
        if (almost_empty !== 1'b1 || almost_full !== 1'b0 || rd_data !== 8'h00) begin
            n_fail++; $display("FAIL async_reset_flags: got ae %b af %b data %h want 1 0 00",
                               almost_empty, almost_full, rd_data);
        end
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        exp_q.delete();
        drive(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (count !== 4'd0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: got count %0d valid %b want 0 0", count, rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_std_read();
        test_fill_drain();
        test_wrap();
        test_full_rw();
        test_fwft();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
